// File: rtl/seven_seg_pkg.sv
// Shared state type and segment patterns for the seven-segment scanner.
// Patterns are a..g with segment a in the MSB; dp is appended by the decoder.
package seven_seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_0   = 7'b1111110;
  localparam logic [6:0] SEG_1   = 7'b0110000;
  localparam logic [6:0] SEG_2   = 7'b1101101;
  localparam logic [6:0] SEG_3   = 7'b1111001;
  localparam logic [6:0] SEG_4   = 7'b0110011;
  localparam logic [6:0] SEG_5   = 7'b1011011;
  localparam logic [6:0] SEG_6   = 7'b1011111;
  localparam logic [6:0] SEG_7   = 7'b1110000;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1111011;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  localparam logic [0:7] SEG_BLANK = 8'b0;

endpackage

// File: rtl/seven_segment_scanner_decoder.sv
// BCD to seven-segment decoder; non-BCD nibbles light nothing but dp still passes.
module bcd_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic       [3:0] bcd,
  input  logic             dp,
  output logic       [0:7] seg
);

  logic [6:0] pattern;

  always_comb begin
    pattern = SEG_OFF;
    case (bcd)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_OFF;
    endcase
  end

  assign seg = {pattern, dp};

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment scanner with dead time and frame-synchronous value commit.
// Define LEADING_ZERO_BLANK_EN to suppress a..g on leading zero digits (digit 0 always shown).
module seven_segment_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  output logic                    load_ready,
  output logic [0:7]              seg,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  scan_state_t state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             running;
  logic             frame_end;

  logic [4*NUM_DIGITS-1:0] disp_data, pend_data;
  logic [NUM_DIGITS-1:0]   disp_dp, pend_dp;
  logic                    pend_full;

  logic [3:0]            nibble;
  logic [0:7]            dec_seg;
  logic [0:7]            seg_nxt;
  logic [NUM_DIGITS-1:0] digit_sel_nxt;
  logic                  blank_lead;

  // The first edge after reset only arms the scanner, so the first SHOW
  // begins BLANK_CYCLES cycles after that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BLANK;
      idx        <= '0;
      cnt        <= '0;
      running    <= 1'b0;
      seg        <= SEG_BLANK;
      digit_sel  <= '0;
      frame_done <= 1'b0;
    end else begin
      running    <= 1'b1;
      state      <= state_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      seg        <= seg_nxt;
      digit_sel  <= digit_sel_nxt;
      frame_done <= frame_end;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    frame_end = 1'b0;
    if (running) begin
      case (state)
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nxt = SHOW;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            frame_end = (idx == LAST_IDX);
            idx_nxt   = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Outputs are computed from the next state so they register on the same
  // edge as the state itself; the displayed value only moves entering BLANK.
  assign nibble = disp_data[4*idx_nxt +: 4];

  bcd_seg_decoder u_decoder (
    .bcd (nibble),
    .dp  (disp_dp[idx_nxt]),
    .seg (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] zero_from;
  logic                  zero_acc;

  always_comb begin
    zero_from = '0;
    zero_acc  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_acc     = zero_acc && (disp_data[4*k +: 4] == 4'd0);
      zero_from[k] = zero_acc;
    end
  end

  assign blank_lead = (idx_nxt != '0) && zero_from[idx_nxt];
`else
  assign blank_lead = 1'b0;
`endif

  always_comb begin
    seg_nxt       = SEG_BLANK;
    digit_sel_nxt = '0;
    if (state_nxt == SHOW) begin
      digit_sel_nxt = NUM_DIGITS'(1) << idx_nxt;
      seg_nxt       = blank_lead ? {SEG_OFF, dec_seg[7]} : dec_seg;
    end
  end

  // Pending is committed only at a frame boundary, and cannot accept while
  // full, so a transfer and a commit never land on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_data <= '0;
      disp_dp   <= '0;
      pend_data <= '0;
      pend_dp   <= '0;
      pend_full <= 1'b0;
    end else if (frame_end && pend_full) begin
      disp_data <= pend_data;
      disp_dp   <= pend_dp;
      pend_full <= 1'b0;
    end else if (load_valid && load_ready) begin
      pend_data <= load_data;
      pend_dp   <= load_dp;
      pend_full <= 1'b1;
    end
  end

  assign load_ready = !pend_full;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench for seven_segment_scanner (4 digits, 4-cycle SHOW, 1-cycle BLANK).
// Expected outputs come from a cycle-position model of the scan and a frame-boundary commit model.
module tb_seven_segment_scanner;

  localparam int ND    = 4;
  localparam int RD    = 4;
  localparam int BC    = 1;
  localparam int SLOT  = RD + BC;
  localparam int FRAME = ND * SLOT;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b1;
  logic        load_valid = 1'b0;
  logic [15:0] load_data  = '0;
  logic [3:0]  load_dp    = '0;
  logic        load_ready;
  logic [0:7]  seg;
  logic [3:0]  digit_sel;
  logic        frame_done;

  typedef struct packed {
    logic [3:0] digit_sel;
    logic [7:0] seg;
    logic       frame_done;
    logic       ready;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int          cyc       = 0;
  logic [15:0] disp      = '0;
  logic [3:0]  disp_dp   = '0;
  logic [15:0] pend      = '0;
  logic [3:0]  pend_dp   = '0;
  logic        pend_full = 1'b0;
  logic        xfer_seen = 1'b0;
  logic        last_bnd  = 1'b0;
  int          n_xfer    = 0;

  seven_segment_scanner #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_dp    (load_dp),
    .load_ready (load_ready),
    .seg        (seg),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %b, want %b at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] data, input logic [3:0] dp);
    load_valid = valid;
    load_data  = data;
    load_dp    = dp;
  endtask

  function automatic logic [6:0] segPattern(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  // Expected outputs for the cycle following the latest edge: position p in
  // the frame gives the slot (BLANK first, then SHOW) and the digit index.
  function automatic exp_t expectNow(input logic bnd);
    exp_t       e;
    int         p;
    int         d;
    logic [6:0] pat;
    e            = '0;
    e.ready      = !pend_full;
    e.frame_done = bnd;
    if (rst_n && cyc > 0) begin
      p = cyc - 1;
      d = (p % FRAME) / SLOT;
      if ((p % SLOT) >= BC) begin
        pat = segPattern(disp[4*d +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && (disp >> (4*d)) == 16'd0) pat = 7'b0000000;
`endif
        e.digit_sel = 4'(1 << d);
        e.seg       = {pat, disp_dp[d]};
      end
    end
    return e;
  endfunction

  task automatic compareOutputs();
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("digit_sel", 16'(digit_sel), 16'(e.digit_sel));
      checkOutput("seg", 16'(seg), 16'(e.seg));
      checkOutput("frame_done", 16'(frame_done), 16'(e.frame_done));
      checkOutput("load_ready", 16'(load_ready), 16'(e.ready));
    end
  endtask

  task automatic modelReset();
    cyc       = 0;
    disp      = '0;
    disp_dp   = '0;
    pend_full = 1'b0;
  endtask

  task automatic tick();
    int p;
    @(posedge clk);
    last_bnd  = 1'b0;
    xfer_seen = 1'b0;
    if (!rst_n) begin
      modelReset();
    end else begin
      cyc++;
      p        = cyc - 1;
      last_bnd = (p > 0) && (p % FRAME == 0);
      if (pend_full && last_bnd) begin
        disp      = pend;
        disp_dp   = pend_dp;
        pend_full = 1'b0;
      end else if (load_valid && !pend_full) begin
        pend      = load_data;
        pend_dp   = load_dp;
        pend_full = 1'b1;
        xfer_seen = 1'b1;
      end
    end
    exp_q.push_back(expectNow(last_bnd));
    @(negedge clk);
    compareOutputs();
  endtask

  // Hold the offer until it is taken or the cycle budget runs out.
  task automatic loadOnce(input logic [15:0] data, input logic [3:0] dp);
    int taken;
    taken = 0;
    applyStimulus(1'b1, data, dp);
    for (int i = 0; i < 3 * FRAME && taken == 0; i++) begin
      tick();
      if (xfer_seen) taken = 1;
    end
    applyStimulus(1'b0, data, dp);
    checkOutput("load_taken", 16'(taken), 16'd1);
  endtask

  initial begin
    int seen;
    applyStimulus(1'b0, 16'h0000, 4'b0000);
    #1 rst_n = 1'b0;
    modelReset();
    repeat (3) tick();
    rst_n = 1'b1;

    // idle frames after reset: digit 0 lit on every digit
    repeat (FRAME + 4) tick();

    // mid-frame load must not appear until the frame boundary
    repeat (5) tick();
    loadOnce(16'h0305, 4'b0010);
    repeat (2 * FRAME) tick();

    // back-to-back loads with valid held: second stalls until after the boundary
    n_xfer = 0;
    applyStimulus(1'b1, 16'h1111, 4'b0000);
    for (int i = 0; i < 4 * FRAME && n_xfer < 2; i++) begin
      tick();
      if (xfer_seen) begin
        n_xfer++;
        if (n_xfer == 1) load_data = 16'h2222;
      end
    end
    applyStimulus(1'b0, 16'h0000, 4'b0000);
    checkOutput("xfer_count", 16'(n_xfer), 16'd2);
    repeat (2 * FRAME + 2) tick();

    // non-BCD nibble with decimal point
    loadOnce(16'h000C, 4'b0001);
    repeat (2 * FRAME) tick();

    // reset in the middle of a SHOW while a value is pending
    seen = 0;
    for (int i = 0; i < 2 * FRAME && seen == 0; i++) begin
      tick();
      if (last_bnd) seen = 1;
    end
    checkOutput("boundary_seen", 16'(seen), 16'd1);
    loadOnce(16'h9999, 4'b1111);
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    modelReset();
    exp_q.push_back(expectNow(1'b0));
    compareOutputs();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (FRAME + 5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 Parameter REFRESH_DIV, default 50000: clk cycles each digit is driven (SHOW time), at least 2.
REQ-003 Parameter BLANK_CYCLES, default 500: clk cycles of inter-digit dead time (BLANK time), at least 1.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 load_valid  input  1  new display value offered.
REQ-007 load_data  input  4*NUM_DIGITS  BCD digits; nibble k is digit k, digit 0 least significant.
REQ-008 load_dp  input  NUM_DIGITS  decimal-point enable per digit.
REQ-009 load_ready  output  1  scanner can accept a value.
REQ-010 seg  output  [0:7]  a,b,c,d,e,f,g,dp, active-high.
REQ-011 digit_sel  output  NUM_DIGITS  one-hot active-high digit enable; bit k drives digit k.
REQ-012 frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-013 The FSM SHALL have two states, BLANK and SHOW, with a digit index idx (0..NUM_DIGITS-1) and a cycle counter.
REQ-014 BLANK SHALL last BLANK_CYCLES cycles with digit_sel=0 and seg=0, then go to SHOW with the same idx.
REQ-015 SHOW SHALL last REFRESH_DIV cycles with digit_sel=1<<idx and seg=decode(digit idx), then go to BLANK with idx+1, wrapping NUM_DIGITS-1 to 0.
REQ-016 digit_sel and seg SHALL be registered and change on the same edge; digit_sel SHALL never be nonzero in BLANK.
REQ-017 Decode SHALL use the standard a..g patterns (0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011).
REQ-018 Nibbles 10..15 SHALL decode to all segments off; dp SHALL equal the digit's load_dp bit regardless.
REQ-019 Handshake: a transfer SHALL occur on a cycle where load_valid and load_ready are both 1; load_data and load_dp go to a pending register and load_ready drops the next cycle.
REQ-020 A frame boundary SHALL be the cycle the FSM leaves SHOW with idx=NUM_DIGITS-1.
REQ-021 At a frame boundary with pending full, the pending value SHALL become the displayed value and load_ready SHALL return to 1 on the next cycle.
REQ-022 frame_done SHALL pulse for one cycle on every frame boundary, whether or not a commit occurs.
REQ-023 The displayed value SHALL never change mid-frame, so there is no tearing.
REQ-024 A transfer and a commit cannot coincide because load_ready is 0 while pending is full; load_valid held through a commit SHALL be accepted on the following cycle.
REQ-025 Frame period SHALL be exactly NUM_DIGITS*(REFRESH_DIV+BLANK_CYCLES) cycles.

Reset
REQ-026 While rst_n=0, outputs SHALL be seg=0, digit_sel=0, frame_done=0, load_ready=1.
REQ-027 Reset SHALL also set state=BLANK, idx=0, counter=0, displayed value=0, displayed dp=0, pending empty.
REQ-028 Reset asserted mid-operation SHALL discard any pending value without committing it.
REQ-029 After release, the first SHOW SHALL start BLANK_CYCLES cycles after the first clock edge.

Configuration
REQ-030 With macro LEADING_ZERO_BLANK_EN defined, a displayed digit SHALL show a..g off when it and all higher digits are 0; digit 0 is never blanked, and digit_sel and dp behave unchanged.
REQ-031 Without LEADING_ZERO_BLANK_EN, every digit SHALL show its decoded value, including leading zeros.

Structure
REQ-032 Package seven_seg_pkg SHALL hold the FSM state enum, the segment-pattern constants and SEG_BLANK=8'b0.
REQ-033 Decoding SHALL be one combinational sub-module, bcd_seg_decoder (4-bit BCD in, [0:7] out), instantiated once on the muxed nibble.

Verification
(All with NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.)
REQ-034 Reset, then 20 cycles idle -> digit_sel sequence 0,0001x4,0,0010x4,0,0100x4,0,1000x4; seg=11111100 during each SHOW; one frame_done every 20 cycles.
REQ-035 Load 16'h0305 with dp=4'b0010 mid-frame -> no change until the boundary; next frame digit0=10110110, digit1=11111101, digit2=11110010, digit3=11111100.
REQ-036 Same stimulus with LEADING_ZERO_BLANK_EN -> digit3 seg=00000000 while digit_sel=1000; other digits as in REQ-035.
REQ-037 Two back-to-back loads 16'h1111 then 16'h2222, valid held -> the second stalls (load_ready=0) until the cycle after the boundary, then commits at the following boundary; no frame shows mixed digits.
REQ-038 Nibble 4'hC with dp=1 -> seg=00000001; rst_n low mid-SHOW with pending full -> outputs 0 immediately, load_ready=1, value 0 after release.
